// File: rtl/seq_accum_alu_pkg.sv
// Shared opcodes, FSM encoding and ERR bit positions for the seq_accum_alu slice.
package seq_accum_alu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_CLR = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_MOD = 4'b0110;
  localparam logic [3:0] OP_PRE = 4'b1110;
  localparam logic [3:0] OP_RES = 4'b1111;

  localparam int ERR_BORROW = 0;
  localparam int ERR_DIVZ   = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative engine: LSB-first shift-add multiply and restoring divide, W iterations each.
// last is high during the final iteration cycle; result then holds the finished value.
module seq_muldiv_unit
  import seq_accum_alu_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_mul,
  input  logic           start_div,
  input  logic           is_mod_in,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output state_t         state,
  output logic           last,
  output logic [2*W-1:0] result
);

  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic           is_mod;
  logic [W-1:0]   a_sh;     // multiplier bits (MUL) or dividend/quotient shift register (DIV)
  logic [2*W-1:0] b_sh;
  logic [2*W-1:0] prod;
  logic [W-1:0]   rem;
  logic [W-1:0]   dvs;

  logic [2*W-1:0] prod_nxt;
  logic [W:0]     shifted;
  logic [W:0]     diff;
  logic           ge;
  logic [W-1:0]   rem_nxt;
  logic [W-1:0]   quo_nxt;

  always_comb begin
    prod_nxt = a_sh[0] ? (prod + b_sh) : prod;
    shifted  = {rem, a_sh[W-1]};
    diff     = shifted - {1'b0, dvs};
    ge       = (shifted >= {1'b0, dvs});
    rem_nxt  = ge ? diff[W-1:0] : shifted[W-1:0];
    quo_nxt  = {a_sh[W-2:0], ge};
    last     = (state != S_IDLE) && (cnt == CW'(W - 1));
    if (state == S_MUL) result = prod_nxt;
    else                result = {{W{1'b0}}, (is_mod ? rem_nxt : quo_nxt)};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_mul)      state_nxt = S_MUL;
        else if (start_div) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_mod <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      prod   <= '0;
      rem    <= '0;
      dvs    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start_mul) begin
            a_sh <= a_in;
            b_sh <= {{W{1'b0}}, b_in};
            prod <= '0;
          end else if (start_div) begin
            a_sh   <= a_in;
            dvs    <= b_in;
            rem    <= '0;
            is_mod <= is_mod_in;
          end
        end
        S_MUL: begin
          prod <= prod_nxt;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh << 1;
          cnt  <= last ? '0 : cnt + 1'b1;
        end
        S_DIV: begin
          rem  <= rem_nxt;
          a_sh <= quo_nxt;
          cnt  <= last ? '0 : cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/seq_accum_alu.sv
// Accumulator calculator: single-cycle ops inline, MUL/DIV/MOD via seq_muldiv_unit.
// Build option SEQ_ACCUM_ALU_STICKY_ERR_EN makes ERR bits accumulate until RST or opcode 1111.
// Handshake: START is accepted on a rising CLK edge only while BUSY=0 (never queued);
// DONE pulses for exactly one cycle after the edge that writes the accumulator.
module seq_accum_alu
  import seq_accum_alu_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = $clog2(W) + 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [W-1:0]   IN1,
  input  logic [3:0]     OP,
  input  logic           START,
  output logic           BUSY,
  output logic           DONE,
  output logic [2*W-1:0] OUT,
  output logic [1:0]     ERR
);

  logic [2*W-1:0] acc;
  logic [1:0]     err;
  logic           done;
  state_t         eng_state;
  logic           eng_last;
  logic [2*W-1:0] eng_result;

  logic [W-1:0]   b_op;
  logic           b_zero;
  logic           accept;
  logic           start_mul;
  logic           start_div;
  logic [2*W-1:0] sc_acc;
  logic [1:0]     sc_err;

  assign b_op      = acc[W-1:0];
  assign b_zero    = (b_op == '0);
  assign BUSY      = (eng_state != S_IDLE);
  assign accept    = START && !BUSY;
  assign start_mul = accept && (OP == OP_MUL);
  assign start_div = accept && ((OP == OP_DIV) || (OP == OP_MOD)) && !b_zero;
  assign OUT       = acc;
  assign ERR       = err;
  assign DONE      = done;

  function automatic logic [1:0] err_merge(input logic [1:0] cur, input logic [1:0] flags,
                                           input logic clear);
`ifdef SEQ_ACCUM_ALU_STICKY_ERR_EN
    return clear ? 2'b00 : (cur | flags);
`else
    return (clear || (cur == 2'b11 && 1'b0)) ? 2'b00 : flags;
`endif
  endfunction

  // Results for every op that completes at the accepting edge, including divide by zero.
  always_comb begin
    sc_acc = '0;
    sc_err = 2'b00;
    case (OP)
      OP_NOP: sc_acc = acc;
      OP_CLR: sc_acc = '0;
      OP_ADD: sc_acc = {{W{1'b0}}, IN1} + {{W{1'b0}}, b_op};
      OP_SUB: begin
        sc_acc             = {{W{1'b0}}, IN1} - {{W{1'b0}}, b_op};
        sc_err[ERR_BORROW] = (IN1 < b_op);
      end
      OP_DIV, OP_MOD: sc_err[ERR_DIVZ] = 1'b1;
      OP_PRE: sc_acc = '1;
      default: sc_acc = '0;
    endcase
  end

  seq_muldiv_unit #(.W(W), .CW(CW)) u_engine (
    .clk       (CLK),
    .rst       (RST),
    .start_mul (start_mul),
    .start_div (start_div),
    .is_mod_in (OP == OP_MOD),
    .a_in      (IN1),
    .b_in      (b_op),
    .state     (eng_state),
    .last      (eng_last),
    .result    (eng_result)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc  <= '0;
      err  <= 2'b00;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (eng_last) begin
        acc  <= eng_result;
        err  <= err_merge(err, 2'b00, 1'b0);
        done <= 1'b1;
      end else if (accept && !start_mul && !start_div) begin
        acc  <= sc_acc;
        err  <= err_merge(err, sc_err, OP == OP_RES);
        done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seq_accum_alu.md
Name: seq_accum_alu

Overview:
- Parametrised, multi-cycle accumulator calculator.
- IN1 is combined with the low half of an internal accumulator (feedback operand) under a 4-bit opcode. The result is written back to the accumulator, which drives OUT.
- Replaces the single-cycle combinational datapath with an iterative shift-add multiplier and a restoring divider, plus a START/BUSY/DONE handshake.
- Sits between operand/opcode source and result display, one instance per calculator channel.

Parameters:
- W, 16, operand width. Accumulator and OUT are 2*W bits.
- CW, clog2(W)+1 (derived), iteration counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN1  in  W  operand A.
- OP  in  4  opcode, captured with START.
- START  in  1  request. Accepted on a rising edge only when BUSY=0.
- BUSY  out  1  multi-cycle operation in progress.
- DONE  out  1  one-cycle pulse: accumulator updated.
- OUT  out  2W  accumulator value.
- ERR  out  2  [0] borrow/overflow, [1] divide/modulo by zero.

Behaviour:
- Reset: RST asynchronously forces ACC=0, ERR=00, BUSY=0, DONE=0, state=IDLE, counter=0. RST mid-operation aborts the operation; there is no partial writeback.
- Operands: A = IN1, B = ACC[W-1:0]. Both are unsigned and zero-extended to 2W.
- Opcodes:
  - 0000 NOP: ACC unchanged.
  - 0001 CLR: ACC=0.
  - 0010 ADD: ACC = A+B.
  - 0011 SUB: ACC = A−B, mod 2^(2W).
  - 0100 MUL: ACC = A*B.
  - 0101 DIV: ACC = A/B.
  - 0110 MOD: ACC = A%B.
  - 0111–1101: ACC=0 (ground).
  - 1110 PRESET: ACC = all ones.
  - 1111 RESET: ACC=0 and ERR=00.
- Capture: IN1 and OP are registered at the accepting edge k. Later changes have no effect until the next accepted START. START while BUSY=1 is ignored and is not queued.
- Single-cycle ops (all except MUL, DIV/MOD with B≠0): ACC written at edge k. DONE=1 for the cycle after edge k. BUSY stays 0. Back-to-back STARTs are allowed every cycle.
- FSM states are IDLE, MUL, DIV.
  - IDLE→MUL on an accepted MUL.
  - IDLE→DIV on an accepted DIV/MOD with B≠0.
  - In MUL or DIV, BUSY=1 after edge k. One iteration per edge k+1..k+W, counter counting 0..W−1.
  - At edge k+W the result is written, BUSY falls, DONE pulses for one cycle, and the FSM returns to IDLE.
  - A START asserted in the same cycle that BUSY is still 1 is ignored.
- MUL: LSB-first shift-add over W bits of A with the captured B. Product fits in 2W, so ERR[0]=0.
- DIV/MOD: restoring division, W iterations, producing quotient and remainder. Quotient or remainder is zero-extended to 2W.
- Divide by zero (B=0 on DIV/MOD): single-cycle. ACC=0, ERR[1]=1, no BUSY.
- ERR[0]: set by SUB when A<B (borrow). ADD/MUL cannot overflow 2W, so they clear it.
- ERR update: on each completed operation ERR takes that operation's flags. NOP and PRESET produce 00.
- DONE is never asserted while BUSY=1, except in the final-write cycle as specified above. DONE=0 after reset.

Optional Feature:
- Macro: SEQ_ACCUM_ALU_STICKY_ERR_EN.
- Defined: ERR bits OR-accumulate across operations. They clear only on RST or opcode 1111.
- Undefined: ERR reflects only the last completed operation, as above.

Decomposition:
- Package seq_accum_alu_pkg holds:
  - the opcode localparams (OP_NOP, OP_CLR, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_PRE, OP_RES);
  - the FSM state encoding (S_IDLE, S_MUL, S_DIV);
  - the ERR bit indices.
- Sub-module seq_muldiv_unit: the iterative engine (shift-add plus restoring divide, counter, done strobe), parametrised by W.
- The top level keeps ACC, ERR, the handshake and the single-cycle ops.

Test Plan:
- RST, then START ADD IN1=10 → OUT=10 one cycle later, DONE 1-cycle pulse, BUSY never 1, ERR=00.
- From ACC=10: START MUL IN1=15 → BUSY=1 for exactly 16 cycles, then OUT=150, DONE pulse, ERR=00. A START issued mid-operation is ignored; OUT is unchanged by it.
- From ACC=150: START SUB IN1=100 → OUT=32'hFFFFFFCE, ERR=01.
- RESET op, ADD IN1=3, then DIV IN1=7 → OUT=2 after 16 busy cycles. Repeat with ACC=3 and MOD IN1=7 → OUT=1.
- CLR, then DIV IN1=9 (B=0) → OUT=0, ERR=10, DONE one cycle later, BUSY stays 0.
- Assert RST at busy cycle 5 of a MUL → OUT=0, BUSY=0, DONE=0, ERR=00 immediately. The next START ADD IN1=4 → OUT=4.
- Sticky build: SUB borrow then ADD → ERR stays 01 until opcode 1111.
